// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg : load-format codes and writeback request type               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cpu_pkg;

   localparam logic [2:0] LDF_LB  = 3'b000;
   localparam logic [2:0] LDF_LH  = 3'b001;
   localparam logic [2:0] LDF_LW  = 3'b010;
   localparam logic [2:0] LDF_LBU = 3'b100;
   localparam logic [2:0] LDF_LHU = 3'b101;

   // Request fields are sized for the widest supported build; narrower
   // builds zero-extend into them.
   localparam int WB_XLEN_MAX = 64;
   localparam int WB_AW_MAX   = 8;

   typedef struct packed {
      logic [WB_AW_MAX-1:0]   rd;
      logic [WB_XLEN_MAX-1:0] data;
      logic                   is_load;
      logic [2:0]             ld_fmt;
      logic [1:0]             addr_lo;
   } wb_req_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_arbiter_if : result channels in, register-file write port out     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface wb_arbiter_if #(
   parameter int NUM_CH = 3,
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
);
   logic [NUM_CH-1:0]        ch_valid;
   logic [NUM_CH-1:0]        ch_ready;
   logic [NUM_CH*REG_AW-1:0] ch_rd;
   logic [NUM_CH*XLEN-1:0]   ch_data;
   logic [NUM_CH-1:0]        ch_is_load;
   logic [NUM_CH*3-1:0]      ch_ld_fmt;
   logic [NUM_CH*2-1:0]      ch_addr_lo;

   logic                     rf_we;
   logic [REG_AW-1:0]        rf_waddr;
   logic [XLEN-1:0]          rf_wdata;
   logic                     fwd_valid;
   logic [REG_AW-1:0]        fwd_rd;
   logic [XLEN-1:0]          fwd_data;

   modport slave (
      input  ch_valid, ch_rd, ch_data, ch_is_load, ch_ld_fmt, ch_addr_lo,
      output ch_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data
   );

   modport master (
      output ch_valid, ch_rd, ch_data, ch_is_load, ch_ld_fmt, ch_addr_lo,
      input  ch_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data
   );
endinterface
`default_nettype wire

// File: rtl/wb_load_fmt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_load_fmt : byte/half alignment and sign/zero extension of loads   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wb_load_fmt
   import cpu_pkg::*;
(
   input  wb_req_t     req,
   output logic [31:0] data_out
);
   logic [31:0] word;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        unused_fields;

   assign word          = req.data[31:0];
   assign unused_fields = ^{req.rd, req.data[WB_XLEN_MAX-1:32]};

   always_comb begin
      byte_sel = word[{req.addr_lo, 3'b000} +: 8];
      // Halfword offset uses only addr_lo[1]; odd offsets round down.
      half_sel = req.addr_lo[1] ? word[31:16] : word[15:0];
      data_out = word;
      if (req.is_load) begin
         case (req.ld_fmt)
            LDF_LB:  data_out = {{24{byte_sel[7]}}, byte_sel};
            LDF_LBU: data_out = {24'h0, byte_sel};
            LDF_LH:  data_out = {{16{half_sel[15]}}, half_sel};
            LDF_LHU: data_out = {16'h0, half_sel};
            LDF_LW:  data_out = word;
            default: data_out = word;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_arbiter : round-robin merge of result channels onto the RF port   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wb_arbiter
   import cpu_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int NUM_CH      = 3,
   parameter int REG_AW      = 5,
   parameter bit LOAD_FMT_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   wb_arbiter_if.slave bus
);
   localparam int            PW      = idx_width(NUM_CH);
   localparam logic [PW-1:0] LAST_CH = PW'(NUM_CH - 1);

   wb_req_t           req [NUM_CH];
   wb_req_t           gnt_req;
   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] drain;
   logic [NUM_CH-1:0] grant_oh;
   logic              gnt_valid;
   logic [PW-1:0]     gnt_idx;
   int                scan;
   logic [XLEN-1:0]   fmt_data;
   logic              unused_req;

   logic [PW-1:0]     ptr_q, ptr_d;
   logic              rf_we_q, rf_we_d;
   logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

   generate
      if (NUM_CH < 1 || NUM_CH > 8 || XLEN > WB_XLEN_MAX || REG_AW > WB_AW_MAX ||
          (LOAD_FMT_EN && XLEN != 32)) begin : g_bad_params
         $error("wb_arbiter: unsupported parameter combination");
      end

      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         assign req[i].rd      = WB_AW_MAX'(bus.ch_rd[i*REG_AW +: REG_AW]);
         assign req[i].data    = WB_XLEN_MAX'(bus.ch_data[i*XLEN +: XLEN]);
         assign req[i].is_load = bus.ch_is_load[i];
         assign req[i].ld_fmt  = bus.ch_ld_fmt[i*3 +: 3];
         assign req[i].addr_lo = bus.ch_addr_lo[i*2 +: 2];
         // Writes to x0 are acknowledged immediately and never compete.
         assign eligible[i] = bus.ch_valid[i] && (bus.ch_rd[i*REG_AW +: REG_AW] != '0);
         assign drain[i]    = bus.ch_valid[i] && (bus.ch_rd[i*REG_AW +: REG_AW] == '0);
      end
   endgenerate

   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      grant_oh  = '0;
      scan      = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         scan = int'(ptr_q) + k;
         if (scan >= NUM_CH) begin
            scan = scan - NUM_CH;
         end
         if (!gnt_valid && eligible[scan]) begin
            gnt_valid      = 1'b1;
            gnt_idx        = scan[PW-1:0];
            grant_oh[scan] = 1'b1;
         end
      end
   end

   always_comb begin
      gnt_req = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_oh[i]) begin
            gnt_req = req[i];
         end
      end
   end

   assign unused_req   = ^gnt_req;
   assign bus.ch_ready = drain | grant_oh;

   generate
      if (LOAD_FMT_EN) begin : g_load_fmt
         logic [31:0] fmt_word;
         wb_load_fmt u_load_fmt (
            .req      (gnt_req),
            .data_out (fmt_word)
         );
         assign fmt_data = XLEN'(fmt_word);
      end else begin : g_no_load_fmt
         assign fmt_data = gnt_req.data[XLEN-1:0];
      end
   endgenerate

   always_comb begin
      ptr_d      = ptr_q;
      rf_we_d    = gnt_valid;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (gnt_valid) begin
         ptr_d      = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
         rf_waddr_d = gnt_req.rd[REG_AW-1:0];
         rf_wdata_d = fmt_data;
      end
   end

   // Reset wins over a concurrent grant: the handshake completes but the
   // result is discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q      <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign bus.rf_we     = rf_we_q;
   assign bus.rf_waddr  = rf_waddr_q;
   assign bus.rf_wdata  = rf_wdata_q;
   assign bus.fwd_valid = rf_we_q;
   assign bus.fwd_rd    = rf_waddr_q;
   assign bus.fwd_data  = rf_wdata_q;
endmodule
`default_nettype wire
